id_ex_hazard_stage: RTL
=======================

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 Parameters SHALL be: LEN, default 32, data/immediate width; NB_ADDR, default 5, register address width; NB_CNT, default 32, stall-counter width.
REQ-002 i_clk  in  1  clock; all state updates on posedge.
REQ-003 i_rst  in  1  reset, synchronous, active-low.
REQ-004 i_enable  in  1  pipeline enable (debug step); low freezes all state.
REQ-005 i_flush  in  1  branch/jump taken; squash instruction entering EX.
REQ-006 i_rs, i_rt, i_rd  in  NB_ADDR each  ID-stage register fields.
REQ-007 i_imm  in  LEN  ID-stage sign-extended immediate.
REQ-008 i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_reg_dst  in  1 each  ID control bits.
REQ-009 i_alu_op  in  2  ID ALU op class.
REQ-010 i_mem_reg_write  in  1, i_mem_dest  in  NB_ADDR  EX/MEM-stage write-back info.
REQ-011 o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src  out  1 each  registered EX controls.
REQ-012 o_alu_op  out  2; o_imm  out  LEN; o_rs, o_rt, o_dest  out  NB_ADDR  registered EX fields.
REQ-013 o_stall  out  1  combinational; freezes PC and IF/ID when high.
REQ-014 o_stall_count  out  NB_CNT  bubbles inserted due to stalls since reset.

Function
REQ-015 o_dest SHALL be captured as i_reg_dst ? i_rd : i_rt.
REQ-016 Register outputs SHALL align with the register file's read-data outputs, which are captured on the same posedge.
REQ-017 Load-use hazard: o_stall SHALL be 1 when o_mem_read=1, o_rt!=0, and (o_rt==i_rs or o_rt==i_rt).
REQ-018 On a posedge with i_enable=1 and o_stall=1, the block SHALL load a bubble: all control outputs 0; o_imm/o_rs/o_rt/o_dest don't-care.
REQ-019 On a posedge with i_enable=1 and i_flush=1, the block SHALL load a bubble; i_flush has priority over stall.
REQ-020 On a posedge with i_enable=1 and no stall/flush, all inputs SHALL be captured (latency 1).
REQ-021 i_enable=0 SHALL hold every register, including o_stall_count; o_stall SHALL still reflect current values.
REQ-022 o_stall_count SHALL increment by 1 on each posedge with i_enable=1 and o_stall=1 and i_flush=0.
REQ-023 o_stall_count SHALL saturate at all-ones, with no wrap.
REQ-024 Register 0 SHALL never cause a hazard.

Reset
REQ-025 When i_rst=0 at posedge, all control outputs, o_imm, o_rs, o_rt, o_dest and o_stall_count SHALL go to 0; reset overrides i_enable.
REQ-026 During and immediately after reset, o_stall SHALL be 0 because o_mem_read=0.

Configuration
REQ-027 Macro MIPS_FORWARD_EN defined: the hazard rule SHALL be REQ-017 only, because EX forwarding resolves other RAW cases.
REQ-028 Macro MIPS_FORWARD_EN undefined: o_stall SHALL also be 1 for either of these RAW hazards on a nonzero source matching i_rs or i_rt:
- (o_reg_write and o_dest) match;
- (i_mem_reg_write and i_mem_dest) match.
REQ-029 The write-back stage SHALL never stall, because the register file writes on negedge.

Structure
REQ-030 Shared package mips_pkg SHALL hold the alu_op encodings, NB_ADDR/LEN defaults and the ZERO_REG constant.
REQ-031 One sub-module hazard_detect (combinational o_stall) SHALL exist; pipeline registers and the counter SHALL stay in the top module.

Verification
REQ-032 Load-use: LW $5 in EX (o_mem_read=1, o_rt=5); ID i_rs=5 -> o_stall=1 for one cycle, next EX controls all 0, o_stall_count=1.
REQ-033 Flush during stall: load-use condition plus i_flush=1 -> bubble loaded, o_stall_count unchanged.
REQ-034 Zero register: o_mem_read=1, o_rt=0, i_rs=0 -> o_stall=0, normal capture.
REQ-035 Enable low: i_enable=0 for 3 cycles with changing inputs -> outputs and count hold; o_stall still asserts.
REQ-036 Without MIPS_FORWARD_EN: ADD writes $7 (o_reg_write=1, o_dest=7), ID i_rt=7 -> stall 1 cycle; then i_mem_dest=7, i_mem_reg_write=1 -> stall 1 more cycle; count=2.
REQ-037 Reset mid-stall: i_rst=0 while o_stall=1 -> next cycle all outputs 0, o_stall=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op classes, default widths and the
// hard-wired zero register index.
package mips_pkg;

    localparam int LEN_DEF     = 32;
    localparam int NB_ADDR_DEF = 5;
    localparam int ZERO_REG    = 0;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection between the instruction in ID and the ones in EX/MEM.
// With MIPS_FORWARD_EN defined only load-use hazards stall; otherwise RAW on EX and MEM also stall.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               i_ex_mem_read,
    input  logic [NB_ADDR-1:0] i_ex_rt,
`ifndef MIPS_FORWARD_EN
    input  logic               i_ex_reg_write,
    input  logic [NB_ADDR-1:0] i_ex_dest,
    input  logic               i_mem_reg_write,
    input  logic [NB_ADDR-1:0] i_mem_dest,
`endif
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    output logic               o_stall
);

    localparam logic [NB_ADDR-1:0] ZERO = NB_ADDR'(ZERO_REG);

    logic load_use;

    assign load_use = i_ex_mem_read && (i_ex_rt != ZERO) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

`ifdef MIPS_FORWARD_EN
    assign o_stall = load_use;
`else
    logic ex_raw;
    logic mem_raw;

    // Write-back never stalls: the register file writes on the falling edge.
    assign ex_raw  = i_ex_reg_write && (i_ex_dest != ZERO) &&
                     ((i_ex_dest == i_id_rs) || (i_ex_dest == i_id_rt));
    assign mem_raw = i_mem_reg_write && (i_mem_dest != ZERO) &&
                     ((i_mem_dest == i_id_rs) || (i_mem_dest == i_id_rt));
    assign o_stall = load_use || ex_raw || mem_raw;
`endif

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with bubble insertion on stall/flush and a saturating stall counter.
// Build option: MIPS_FORWARD_EN restricts stalls to load-use hazards.
module id_ex_hazard_stage
    import mips_pkg::*;
#(
    parameter int LEN     = LEN_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic [NB_ADDR-1:0] i_rs,
    input  logic [NB_ADDR-1:0] i_rt,
    input  logic [NB_ADDR-1:0] i_rd,
    input  logic [LEN-1:0]     i_imm,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_mem_to_reg,
    input  logic               i_alu_src,
    input  logic               i_reg_dst,
    input  logic [1:0]         i_alu_op,
    input  logic               i_mem_reg_write,
    input  logic [NB_ADDR-1:0] i_mem_dest,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_alu_src,
    output logic [1:0]         o_alu_op,
    output logic [LEN-1:0]     o_imm,
    output logic [NB_ADDR-1:0] o_rs,
    output logic [NB_ADDR-1:0] o_rt,
    output logic [NB_ADDR-1:0] o_dest,
    output logic               o_stall,
    output logic [NB_CNT-1:0]  o_stall_count
);

    logic               reg_write_q, reg_write_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               alu_src_q, alu_src_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic [LEN-1:0]     imm_q, imm_d;
    logic [NB_ADDR-1:0] rs_q, rs_d;
    logic [NB_ADDR-1:0] rt_q, rt_d;
    logic [NB_ADDR-1:0] dest_q, dest_d;
    logic [NB_CNT-1:0]  stall_count_q, stall_count_d;
    logic               stall;

    hazard_detect #(
        .NB_ADDR (NB_ADDR)
    ) u_hazard_detect (
        .i_ex_mem_read   (mem_read_q),
        .i_ex_rt         (rt_q),
`ifndef MIPS_FORWARD_EN
        .i_ex_reg_write  (reg_write_q),
        .i_ex_dest       (dest_q),
        .i_mem_reg_write (i_mem_reg_write),
        .i_mem_dest      (i_mem_dest),
`endif
        .i_id_rs         (i_rs),
        .i_id_rt         (i_rt),
        .o_stall         (stall)
    );

    always_comb begin
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        alu_src_d     = alu_src_q;
        alu_op_d      = alu_op_q;
        imm_d         = imm_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        dest_d        = dest_q;
        stall_count_d = stall_count_q;
        if (i_enable) begin
            // Data fields are captured even for a bubble; with all controls low they are inert.
            imm_d  = i_imm;
            rs_d   = i_rs;
            rt_d   = i_rt;
            dest_d = i_reg_dst ? i_rd : i_rt;
            if (i_flush || stall) begin
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                alu_src_d    = 1'b0;
                alu_op_d     = ALU_ADD;
            end else begin
                reg_write_d  = i_reg_write;
                mem_read_d   = i_mem_read;
                mem_write_d  = i_mem_write;
                mem_to_reg_d = i_mem_to_reg;
                alu_src_d    = i_alu_src;
                alu_op_d     = i_alu_op;
            end
            if (stall && !i_flush && !(&stall_count_q)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            alu_src_q     <= 1'b0;
            alu_op_q      <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            dest_q        <= '0;
            stall_count_q <= '0;
        end else begin
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            alu_src_q     <= alu_src_d;
            alu_op_q      <= alu_op_d;
            imm_q         <= imm_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            dest_q        <= dest_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_reg_write   = reg_write_q;
    assign o_mem_read    = mem_read_q;
    assign o_mem_write   = mem_write_q;
    assign o_mem_to_reg  = mem_to_reg_q;
    assign o_alu_src     = alu_src_q;
    assign o_alu_op      = alu_op_q;
    assign o_imm         = imm_q;
    assign o_rs          = rs_q;
    assign o_rt          = rt_q;
    assign o_dest        = dest_q;
    assign o_stall       = stall;
    assign o_stall_count = stall_count_q;

endmodule
